// File: rtl/tm1637_pkg.sv
// tm1637_pkg: TM1637 command constants, controller FSM states and the hex-to-segment table.
package tm1637_pkg;

    localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
    localparam logic [7:0] CMD_ADDR0     = 8'hC0;
    localparam logic [7:0] CMD_DISP      = 8'h80;
    localparam int         DISP_ON_BIT   = 3;

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_HI, WAIT_LO, NEXT, FINISH} state_t;

    // gfedcba patterns for hex digits 0..F
    localparam logic [6:0] SEG7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg7(input logic [3:0] hex);
        return SEG7[hex];
    endfunction

endpackage

// File: rtl/tm1637_hex_seg.sv
// tm1637_hex_seg: hex nibble plus decimal point to TM1637 segment byte.
module tm1637_hex_seg
    import tm1637_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {dp, seg7(hex)};

endmodule

// File: rtl/tm1637_display_ctrl.sv
// tm1637_display_ctrl: snapshots digits/brightness and streams the TM1637 frame to the byte engine.
// Define TM1637_HEX_DECODE_EN to treat each digit byte as {dp, xxx, hex} and decode it.
module tm1637_display_ctrl
    import tm1637_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    update,
    input  logic [8*NUM_DIGITS-1:0] seg_data,
    input  logic [2:0]              brightness,
    input  logic                    display_on,
    output logic                    ready,
    output logic                    done,
    output logic                    error,
    output logic                    tx_latch,
    output logic [7:0]              tx_byte,
    output logic                    tx_stop,
    input  logic                    tx_busy
);

    localparam int              IW   = $clog2(NUM_DIGITS + 3);
    localparam logic [IW-1:0]   LAST = IW'(NUM_DIGITS + 2);

    state_t                  state, state_nxt;
    logic                    pending;
    logic [IW-1:0]           idx;
    logic [7:0]              cnt;
    logic [8*NUM_DIGITS-1:0] sh_seg;
    logic [2:0]              sh_bright;
    logic                    sh_on;
    logic [7:0]              last_byte;
    logic                    last_stop;
    logic [7:0]              raw_digit;
    logic [7:0]              digit_byte;
    logic [7:0]              cur_byte;
    logic                    cur_stop;
    logic                    timeout;

    always_comb begin
        raw_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (idx == IW'(i + 2)) raw_digit = sh_seg[8*i +: 8];
    end

`ifdef TM1637_HEX_DECODE_EN
    logic unused_digit_bits;
    assign unused_digit_bits = ^raw_digit[6:4];
    tm1637_hex_seg u_hex_seg (
        .hex (raw_digit[3:0]),
        .dp  (raw_digit[7]),
        .seg (digit_byte)
    );
`else
    assign digit_byte = raw_digit;
`endif

    always_comb begin
        cur_byte = (idx == '0)       ? CMD_DATA_AUTO :
                   (idx == IW'(1))   ? CMD_ADDR0 :
                   (idx == LAST)     ? (CMD_DISP | (8'(sh_on) << DISP_ON_BIT) | 8'(sh_bright)) :
                                       digit_byte;
        cur_stop = (idx == '0) || (idx == IW'(NUM_DIGITS + 1)) || (idx == LAST);
    end

    assign timeout  = (state == WAIT_HI) && !tx_busy && (cnt == 8'(BUSY_TIMEOUT - 1));
    assign tx_latch = (state == ISSUE) && !tx_busy;
    assign tx_byte  = tx_latch ? cur_byte : last_byte;
    assign tx_stop  = tx_latch ? cur_stop : last_stop;
    assign done     = state == FINISH;
    assign error    = timeout;
    assign ready    = (state == IDLE) && !pending && !update;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (update || pending) ? LOAD : IDLE;
            LOAD:    state_nxt = ISSUE;
            ISSUE:   state_nxt = tx_busy ? ISSUE : WAIT_HI;
            WAIT_HI: state_nxt = tx_busy ? WAIT_LO : timeout ? IDLE : WAIT_HI;
            WAIT_LO: state_nxt = tx_busy ? WAIT_LO : NEXT;
            NEXT:    state_nxt = (idx == LAST) ? FINISH : ISSUE;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pending   <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            sh_seg    <= '0;
            sh_bright <= '0;
            sh_on     <= 1'b0;
            last_byte <= '0;
            last_stop <= 1'b0;
        end else begin
            state   <= state_nxt;
            // a request arriving during LOAD still earns a re-run
            pending <= (update && state != IDLE) || (pending && state != LOAD);
            cnt     <= (state == WAIT_HI) ? cnt + 8'd1 : 8'd0;
            if (state == LOAD) begin
                sh_seg    <= seg_data;
                sh_bright <= brightness;
                sh_on     <= display_on;
                idx       <= '0;
            end
            if (state == NEXT && idx != LAST) idx <= idx + 1'b1;
            if (tx_latch) begin
                last_byte <= cur_byte;
                last_stop <= cur_stop;
            end
        end
    end

endmodule
